// File: rtl/button_events.sv
`default_nettype none
// ============================================================================
// Module      : button_events
// Description : Turns one debounced button level into registered one-cycle
//               event pulses (press, release, auto-repeat, optional
//               long-press) plus a registered held level. One instance per
//               button, placed between the debouncer and paddle/menu logic.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TICK_DIV       clock cycles per timing tick (>= 2)
//   REPEAT_DELAY   ticks from o_press to the first o_repeat (>= 1)
//   REPEAT_PERIOD  ticks between subsequent o_repeat pulses (>= 1)
//   LONG_TICKS     ticks from o_press to o_long (>= 1)
// Ports
//   i_clk      in   system clock, single domain
//   i_rst      in   synchronous reset, active-high
//   i_level    in   debounced button level, 1 = pressed
//   o_press    out  one-cycle pulse on a 0->1 level change
//   o_release  out  one-cycle pulse on a 1->0 level change
//   o_repeat   out  one-cycle auto-repeat pulse while held
//   o_long     out  one-cycle pulse once per hold after LONG_TICKS ticks
//   o_held     out  registered pressed level
// Configuration
//   BUTTON_EVENTS_LONG_EN  defined: long-press counter and o_long are built.
//                          undefined: o_long is tied low.
// ============================================================================
module button_events #(
  parameter int TICK_DIV      = 60000,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 20,
  parameter int LONG_TICKS    = 200
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_long,
  output logic o_held
);

  // --------------------------------------------------------------------------
  // Derived widths and terminal counts
  // --------------------------------------------------------------------------
  localparam int MAX_RPT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_RPT + 1);
  localparam int PRE_W   = $clog2(TICK_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Level pipeline and edge detection
  // --------------------------------------------------------------------------
  logic lvl_q;
  logic prev_q;
  logic rise;
  logic fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      lvl_q  <= i_level;
      prev_q <= lvl_q;
    end
  end

  assign rise = lvl_q & ~prev_q;
  assign fall = ~lvl_q & prev_q;

  // --------------------------------------------------------------------------
  // Event FSM state (declared early so the prescaler can see it)
  // --------------------------------------------------------------------------
  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             press_now;

  // A press is only accepted from IDLE; the level pipeline makes a rising
  // edge outside IDLE impossible, but gating keeps the FSM self-consistent.
  assign press_now = rise && (state == IDLE);

  // --------------------------------------------------------------------------
  // Tick prescaler
  // Restarted in the press cycle so that every hold-time measurement is an
  // exact multiple of TICK_DIV counted from o_press, independent of where
  // the free-running phase happened to be.
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0] presc;
  logic             tick;

  assign tick = (presc == PRE_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc <= '0;
    end else if (press_now || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Event FSM with registered outputs
  // A falling edge has priority over any timer expiry in the same cycle, so
  // o_release never shares a cycle with o_repeat.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_repeat  <= 1'b0;
      o_held    <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_repeat  <= 1'b0;
      o_held    <= lvl_q;

      case (state)
        IDLE: begin
          if (rise) begin
            o_press  <= 1'b1;
            tick_cnt <= '0;
            state    <= DELAY;
          end
        end

        DELAY: begin
          if (fall) begin
            o_release <= 1'b1;
            tick_cnt  <= '0;
            state     <= IDLE;
          end else if (tick) begin
            if (tick_cnt == DLY_LAST) begin
              o_repeat <= 1'b1;
              tick_cnt <= '0;
              state    <= REPEAT;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        REPEAT: begin
          if (fall) begin
            o_release <= 1'b1;
            tick_cnt  <= '0;
            state     <= IDLE;
          end else if (tick) begin
            if (tick_cnt == PER_LAST) begin
              o_repeat <= 1'b1;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          tick_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional long-press detector
  // Counts ticks since o_press and saturates at LONG_TICKS, so exactly one
  // o_long is produced per hold no matter how long the button stays down.
  // --------------------------------------------------------------------------
`ifdef BUTTON_EVENTS_LONG_EN
  localparam int LONG_W = $clog2(LONG_TICKS + 1);

  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_TICKS);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_TICKS - 1);

  logic [LONG_W-1:0] long_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      long_cnt <= '0;
      o_long   <= 1'b0;
    end else begin
      o_long <= 1'b0;
      if (press_now || fall) begin
        // Release wins over a coincident expiry: the counter clears and
        // no pulse is issued.
        long_cnt <= '0;
      end else if ((state != IDLE) && tick && (long_cnt != LONG_SAT)) begin
        long_cnt <= long_cnt + 1'b1;
        if (long_cnt == LONG_LAST) begin
          o_long <= 1'b1;
        end
      end
    end
  end
`else
  // LONG_TICKS stays in the parameter list so both builds share one
  // instantiation; it has no effect here and the term below is constant 0.
  assign o_long = 1'b0 & (LONG_TICKS < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_events.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_events
// Description : Self-checking bench for button_events. Stimulus tasks push
//               expected pulse events (cycle + pulse vector) into a queue;
//               a monitor pops and compares whenever a pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_events;

  localparam int TICK_DIV      = 4;
  localparam int REPEAT_DELAY  = 3;
  localparam int REPEAT_PERIOD = 2;
  localparam int LONG_TICKS    = 5;

  // Cycle offsets from o_press
  localparam int DLY_CYC  = 12;   // 3 ticks * 4 cycles
  localparam int PER_CYC  = 8;    // 2 ticks * 4 cycles
  localparam int LONG_CYC = 20;   // 5 ticks * 4 cycles

`ifdef BUTTON_EVENTS_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  // Pulse vector order: {press, release, repeat, long}
  localparam logic [3:0] EV_PRESS   = 4'b1000;
  localparam logic [3:0] EV_RELEASE = 4'b0100;

  logic clk = 1'b0;
  logic i_rst;
  logic i_level;
  logic o_press;
  logic o_release;
  logic o_repeat;
  logic o_long;
  logic o_held;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } ev_t;

  ev_t sb[$];

  button_events #(
    .TICK_DIV      (TICK_DIV),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .LONG_TICKS    (LONG_TICKS)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_level   (i_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_repeat  (o_repeat),
    .o_long    (o_long),
    .o_held    (o_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d required<%0d", cyc, 20000);
    $fatal(1, "watchdog");
  end

  // Monitor: every observed pulse must match the head of the scoreboard
  always @(negedge clk) begin
    logic [3:0] vec;
    ev_t        exp_ev;
    vec = {o_press, o_release, o_repeat, o_long};
    if (vec != 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: cycle=%0d got=%b required=none", cyc, vec);
      end else begin
        exp_ev = sb.pop_front();
        if (exp_ev.cyc != cyc || exp_ev.vec != vec) begin
          failures++;
          $display("FAIL event: got cycle=%0d vec=%b required cycle=%0d vec=%b",
                   cyc, vec, exp_ev.cyc, exp_ev.vec);
        end
      end
    end
  end

  function automatic void push(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endfunction

  // Expected repeat/long pulses strictly between press cycle e and cycle stop
  function automatic void push_hold_events(input int e, input int stop);
    for (int c = e + 1; c < stop; c++) begin
      int   d;
      logic rep;
      logic lng;
      d   = c - e;
      rep = (d >= DLY_CYC) && (((d - DLY_CYC) % PER_CYC) == 0);
      lng = LONG_EN && (d == LONG_CYC);
      if (rep || lng) push(c, {2'b00, rep, lng});
    end
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: cycle=%0d got=%b required=%b", name, cyc, got, req);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: pending_events=%0d required=0 (next cycle=%0d vec=%b)",
               name, sb.size(), sb[0].cyc, sb[0].vec);
      sb.delete();
    end
  endtask

  // Level high for len cycles, then low; all inputs driven on negedges.
  task automatic hold(input string name, input int len, input int gap);
    int p, e, r;
    @(negedge clk);
    p = cyc;
    e = p + 2;
    r = p + len + 2;
    push(e, EV_PRESS);
    push_hold_events(e, r);
    push(r, EV_RELEASE);
    i_level = 1'b1;
    if (p + len < e) begin
      wait_cyc(p + len);
      i_level = 1'b0;
      wait_cyc(e);
      check_bit({name, "_held_on"}, o_held, 1'b1);
    end else begin
      wait_cyc(e - 1);
      check_bit({name, "_held_pre"}, o_held, 1'b0);
      wait_cyc(e);
      check_bit({name, "_held_on"}, o_held, 1'b1);
      wait_cyc(p + len);
      i_level = 1'b0;
    end
    wait_cyc(r);
    check_bit({name, "_held_off"}, o_held, 1'b0);
    wait_cyc(r + gap);
    check_drained({name, "_drained"});
  endtask

  initial begin
    int p, e, a, e2;
    i_rst   = 1'b1;
    i_level = 1'b0;

    // 1. Reset, then idle level: no events at all
    repeat (3) @(negedge clk);
    check_bit("reset_pulses", |{o_press, o_release, o_repeat, o_long}, 1'b0);
    check_bit("reset_held", o_held, 1'b0);
    i_rst = 1'b0;
    repeat (50) @(negedge clk);
    check_bit("idle_held", o_held, 1'b0);
    check_drained("idle_drained");

    // 2. Long hold: repeats at +12/+20/+28, long at +20
    hold("long_hold", 34, 12);
    // 3. Release before the first repeat
    hold("short_hold", 10, 10);
    // 4. Falling edge in the first repeat expiry cycle: release wins
    hold("edge_expiry", 12, 10);
    // Release coinciding with repeat and long expiry: both suppressed
    hold("edge_long", 20, 10);
    // One repeat then release the following cycle
    hold("one_repeat", 13, 10);
    // 6. One-cycle pulse
    hold("pulse", 1, 10);

    // 5. Reset mid-hold while in REPEAT
    @(negedge clk);
    p = cyc;
    e = p + 2;
    push(e, EV_PRESS);
    push(e + DLY_CYC, 4'b0010);
    i_level = 1'b1;
    a = e + 16;
    wait_cyc(a);
    check_bit("rst_held_before", o_held, 1'b1);
    i_rst = 1'b1;
    wait_cyc(a + 1);
    check_bit("rst_held_cleared", o_held, 1'b0);
    check_drained("rst_first_hold_drained");
    e2 = a + 3;
    push(e2, EV_PRESS);
    push_hold_events(e2, e2 + 24);
    push(e2 + 24, EV_RELEASE);
    i_rst = 1'b0;
    wait_cyc(e2);
    check_bit("rst_repress_held", o_held, 1'b1);
    wait_cyc(e2 + 22);
    i_level = 1'b0;
    wait_cyc(e2 + 36);
    check_drained("rst_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
